transmissor_oled_spi: RTL and testbench
=======================================

Name: transmissor_oled_spi

Overview:
- Reads the 1024-byte monochrome frame (128x64, 8192-bit bus) produced by the image controller and streams it to an SSD1306 OLED over 4-wire SPI (SCLK, MOSI, D/C, CS, RES).
- Performs the panel hardware reset and command initialisation once after reset.
- After initialisation, sends one full frame per accepted refresh request.
- Sits between the image controller and the top-level display pins.

Parameters:
CLK_DIV, 4, system clocks per SCLK half-period (>=1); one bit = 2*CLK_DIV clocks
RST_CYCLES, 50000, clocks res_n is held low after reset; also the wait after res_n rises before init

Ports:
clk  input  1  system clock; all logic on posedge
rst_n  input  1  asynchronous active-low reset
imagem  input  8192  frame; byte i = imagem[i*8 +: 8]
atualizar  input  1  refresh request, single-cycle or level
ocupado  output  1  high from reset until IDLE is reached, and during every frame
pronto  output  1  one-cycle pulse at end of each frame
oled_sclk  output  1  SPI clock, mode 0
oled_mosi  output  1  SPI data, MSB first
oled_dc  output  1  0 = command byte, 1 = data byte
oled_cs_n  output  1  chip select, active low
oled_res_n  output  1  panel hardware reset, active low

Behaviour:
- Reset (async assert, sync release):
  - Outputs: sclk=0, mosi=0, dc=0, cs_n=1, res_n=0, ocupado=1, pronto=0.
  - State RST_LOW; pending flag cleared; snapshot register cleared.
  - Reset asserted mid-byte or mid-frame aborts immediately and restarts the full power-up sequence.
- States:
  - RST_LOW: res_n=0 for RST_CYCLES clocks -> RST_WAIT.
  - RST_WAIT: res_n=1 for RST_CYCLES clocks -> INIT.
  - INIT: send 10 init bytes with dc=0: AE 20 00 8D 14 A1 C8 81 7F AF -> IDLE.
  - IDLE: ocupado=0, cs_n=1. Go to ADDR when atualizar or pending is set.
  - ADDR: send 21 00 7F 22 00 07 with dc=0 (column 0-127, page 0-7).
  - DATA: send 1024 bytes with dc=1. Byte i goes to page i/128, column i%128 (horizontal addressing).
  - FIM: pronto=1 for one clock -> IDLE.
- Snapshot:
  - On the clock edge where IDLE accepts a request, imagem is copied to an internal 8192-bit register.
  - Changes to imagem during the frame are ignored.
- SPI bit timing (mode 0):
  - sclk idles low. mosi and dc are valid at least CLK_DIV clocks before each rising edge.
  - Each bit is sclk low for CLK_DIV clocks, then high for CLK_DIV clocks.
  - Bytes are back to back with no gap, so one byte = 16*CLK_DIV clocks.
- cs_n:
  - Goes low one clock before the first sclk-low phase of INIT, and of ADDR.
  - Stays low through all bytes of INIT, and through ADDR+DATA.
  - Goes high in the clock after the last bit's high phase ends.
- Latency:
  - Request accepted at edge T: cs_n=0 and ocupado=1 from T+1.
  - pronto=1 at T+2+1030*16*CLK_DIV; ocupado=0 from the following clock.
- Requests during busy:
  - atualizar while ocupado=1 (including INIT and FIM cycles) sets a one-deep pending flag; further requests are merged.
  - Pending starts a new frame from IDLE on the next clock, with a new snapshot taken then.
  - atualizar in the same cycle as pronto counts as pending.
- Counters:
  - Bit counter 0-7, byte counter 0-1023 (10 bits), clock divider 0..CLK_DIV-1, reset counter sized by $clog2(RST_CYCLES+1).
  - No counter may wrap silently; every terminal count causes a state transition.

Decomposition:
- Package oled_pkg:
  - state enum
  - N_INIT=10, N_ADDR=6, N_BYTES=1024
  - init ROM and address-command ROM as constant byte arrays
- Sub-module serializador_spi:
  - inputs inicio, byte_in, dc_in
  - outputs sclk, mosi, dc, pronto_byte
  - parameter CLK_DIV
- The top level holds the FSM, snapshot, byte counter, reset timer, cs_n and res_n.

Test Plan (CLK_DIV=2, RST_CYCLES=8 unless noted):
- Release rst_n -> res_n low 8 clocks, high 8 clocks. SPI monitor decodes 10 bytes, dc=0, AE 20 00 8D 14 A1 C8 81 7F AF. ocupado then falls.
- imagem byte0=0xA5, byte1023=0x3C, others 0x00; atualizar pulse -> 6 command bytes 21 00 7F 22 00 07, then 1024 data bytes with dc=1 (first A5, last 3C). pronto at T+2+1030*32.
- Change imagem to all 0xFF mid-frame -> remainder of frame still carries the original snapshot; next requested frame is all FF.
- atualizar pulsed 3 times during a frame -> exactly one extra frame, starting 1 clock after pronto. No third frame.
- Assert rst_n low at data byte 500 -> outputs at reset values within the same cycle. On release, the full RST_LOW/RST_WAIT/INIT sequence repeats.
- CLK_DIV=1 -> sclk period 2 clocks; mosi stable at every rising edge; byte = 16 clocks.

Source files
------------

// File: rtl/oled_pkg.sv
// Shared types and command tables for the SSD1306 SPI transmitter.
// Holds the FSM state enum, byte counts and the init/address ROMs.
package oled_pkg;

    typedef enum logic [2:0] {
        RST_LOW,
        RST_WAIT,
        INIT,
        IDLE,
        ADDR,
        DATA,
        FIM
    } estado_t;

    localparam int N_INIT  = 10;
    localparam int N_ADDR  = 6;
    localparam int N_BYTES = 1024;

    // Element 0 is the rightmost entry: AE is sent first, AF last.
    localparam logic [N_INIT-1:0][7:0] INIT_ROM = {
        8'hAF, 8'h7F, 8'h81, 8'hC8, 8'hA1,
        8'h14, 8'h8D, 8'h00, 8'h20, 8'hAE
    };

    // Column window 0..127, page window 0..7 (sent as 21 00 7F 22 00 07).
    localparam logic [N_ADDR-1:0][7:0] ADDR_ROM = {
        8'h07, 8'h00, 8'h22,
        8'h7F, 8'h00, 8'h21
    };

endpackage

// File: rtl/transmissor_oled_spi_if.sv
// Panel-side pin bundle of the SSD1306 4-wire SPI link.
// master drives sclk/mosi/dc/cs_n/res_n; slave observes them.
interface transmissor_oled_spi_if;

    logic sclk;
    logic mosi;
    logic dc;
    logic cs_n;
    logic res_n;

    modport master (
        output sclk,
        output mosi,
        output dc,
        output cs_n,
        output res_n
    );

    modport slave (
        input sclk,
        input mosi,
        input dc,
        input cs_n,
        input res_n
    );

endinterface

// File: rtl/transmissor_oled_spi_serializador_spi.sv
// SPI mode-0 byte serializer, MSB first, CLK_DIV clocks per half bit.
// Ports: inicio/byte_in/dc_in load a byte; sclk/mosi/dc drive the pins;
// pronto_byte marks the last clock of a byte (reload there = no gap).
module serializador_spi #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inicio,
    input  logic [7:0] byte_in,
    input  logic       dc_in,
    output logic       sclk,
    output logic       mosi,
    output logic       dc,
    output logic       pronto_byte
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_FIM = DW'(CLK_DIV - 1);

    logic          ativo_q;
    logic          fase_q;
    logic [DW-1:0] div_q;
    logic [2:0]    bit_q;
    logic [6:0]    shift_q;
    logic          sclk_q;
    logic          mosi_q;
    logic          dc_q;
    logic          fim_meia;

    assign fim_meia    = (div_q == DIV_FIM);
    assign pronto_byte = ativo_q & fase_q & fim_meia
                       & (bit_q == 3'd7);

    assign sclk = sclk_q;
    assign mosi = mosi_q;
    assign dc   = dc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ativo_q <= 1'b0;
            fase_q  <= 1'b0;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            dc_q    <= 1'b0;
        end else if (!ativo_q || pronto_byte) begin
            // Idle, or last clock of a byte: load the next one or stop.
            fase_q <= 1'b0;
            div_q  <= '0;
            bit_q  <= '0;
            sclk_q <= 1'b0;
            if (inicio) begin
                ativo_q <= 1'b1;
                shift_q <= byte_in[6:0];
                mosi_q  <= byte_in[7];
                dc_q    <= dc_in;
            end else begin
                ativo_q <= 1'b0;
            end
        end else if (fim_meia) begin
            div_q <= '0;
            if (!fase_q) begin
                fase_q <= 1'b1;
                sclk_q <= 1'b1;
            end else begin
                fase_q  <= 1'b0;
                sclk_q  <= 1'b0;
                bit_q   <= bit_q + 3'd1;
                mosi_q  <= shift_q[6];
                shift_q <= {shift_q[5:0], 1'b0};
            end
        end else begin
            div_q <= div_q + DW'(1);
        end
    end

endmodule

// File: rtl/transmissor_oled_spi.sv
// Streams a 128x64 frame to an SSD1306 over SPI after panel reset/init.
// Ports: clk, rst_n, imagem (frame), atualizar (request), ocupado, pronto,
// oled (sclk/mosi/dc/cs_n/res_n pin bundle).
module transmissor_oled_spi
    import oled_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int RST_CYCLES = 50000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [8191:0]          imagem,
    input  logic                   atualizar,
    output logic                   ocupado,
    output logic                   pronto,
    transmissor_oled_spi_if.master oled
);

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam logic [RW-1:0] RST_FIM = RW'(RST_CYCLES - 1);

    estado_t        estado_q;
    logic [9:0]     cnt_q;
    logic [RW-1:0]  rst_cnt_q;
    logic [8191:0]  snap_q;
    logic           pend_q;
    logic           primeiro_q;
    logic           cs_n_q;
    logic           res_n_q;
    logic           ocupado_q;
    logic           pronto_q;

    logic           inicio;
    logic [7:0]     byte_in;
    logic           dc_in;
    logic           pronto_byte;
    logic [9:0]     nxt;
    logic           ser_sclk;
    logic           ser_mosi;
    logic           ser_dc;

    serializador_spi #(
        .CLK_DIV(CLK_DIV)
    ) u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .inicio     (inicio),
        .byte_in    (byte_in),
        .dc_in      (dc_in),
        .sclk       (ser_sclk),
        .mosi       (ser_mosi),
        .dc         (ser_dc),
        .pronto_byte(pronto_byte)
    );

    assign oled.sclk  = ser_sclk;
    assign oled.mosi  = ser_mosi;
    assign oled.dc    = ser_dc;
    assign oled.cs_n  = cs_n_q;
    assign oled.res_n = res_n_q;
    assign ocupado    = ocupado_q;
    assign pronto     = pronto_q;

    // Next byte is offered on the serializer's last clock so that
    // bytes run back to back; primeiro_q starts each burst.
    always_comb begin
        nxt     = cnt_q + 10'd1;
        inicio  = 1'b0;
        byte_in = '0;
        dc_in   = 1'b0;
        unique case (estado_q)
            INIT: begin
                if (primeiro_q) begin
                    inicio  = 1'b1;
                    byte_in = INIT_ROM[0];
                end else if (pronto_byte &&
                             cnt_q != 10'(N_INIT - 1)) begin
                    inicio  = 1'b1;
                    byte_in = INIT_ROM[nxt[3:0]];
                end
            end
            ADDR: begin
                if (primeiro_q) begin
                    inicio  = 1'b1;
                    byte_in = ADDR_ROM[0];
                end else if (pronto_byte) begin
                    inicio = 1'b1;
                    if (cnt_q == 10'(N_ADDR - 1)) begin
                        byte_in = snap_q[7:0];
                        dc_in   = 1'b1;
                    end else begin
                        byte_in = ADDR_ROM[nxt[2:0]];
                    end
                end
            end
            DATA: begin
                if (pronto_byte &&
                    cnt_q != 10'(N_BYTES - 1)) begin
                    inicio  = 1'b1;
                    dc_in   = 1'b1;
                    byte_in = snap_q[{nxt, 3'b000} +: 8];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q   <= RST_LOW;
            cnt_q      <= '0;
            rst_cnt_q  <= '0;
            snap_q     <= '0;
            pend_q     <= 1'b0;
            primeiro_q <= 1'b0;
            cs_n_q     <= 1'b1;
            res_n_q    <= 1'b0;
            ocupado_q  <= 1'b1;
            pronto_q   <= 1'b0;
        end else begin
            pronto_q <= 1'b0;
            if (atualizar && estado_q != IDLE)
                pend_q <= 1'b1;
            if (inicio)
                primeiro_q <= 1'b0;
            unique case (estado_q)
                RST_LOW: begin
                    if (rst_cnt_q == RST_FIM) begin
                        rst_cnt_q <= '0;
                        res_n_q   <= 1'b1;
                        estado_q  <= RST_WAIT;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + RW'(1);
                    end
                end
                RST_WAIT: begin
                    if (rst_cnt_q == RST_FIM) begin
                        rst_cnt_q  <= '0;
                        cnt_q      <= '0;
                        cs_n_q     <= 1'b0;
                        primeiro_q <= 1'b1;
                        estado_q   <= INIT;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + RW'(1);
                    end
                end
                INIT: begin
                    if (pronto_byte) begin
                        if (cnt_q == 10'(N_INIT - 1)) begin
                            cs_n_q    <= 1'b1;
                            ocupado_q <= 1'b0;
                            estado_q  <= IDLE;
                        end else begin
                            cnt_q <= nxt;
                        end
                    end
                end
                IDLE: begin
                    if (atualizar || pend_q) begin
                        snap_q     <= imagem;
                        pend_q     <= 1'b0;
                        cnt_q      <= '0;
                        primeiro_q <= 1'b1;
                        cs_n_q     <= 1'b0;
                        ocupado_q  <= 1'b1;
                        estado_q   <= ADDR;
                    end
                end
                ADDR: begin
                    if (pronto_byte) begin
                        if (cnt_q == 10'(N_ADDR - 1)) begin
                            cnt_q    <= '0;
                            estado_q <= DATA;
                        end else begin
                            cnt_q <= nxt;
                        end
                    end
                end
                DATA: begin
                    if (pronto_byte) begin
                        if (cnt_q == 10'(N_BYTES - 1)) begin
                            cs_n_q   <= 1'b1;
                            pronto_q <= 1'b1;
                            estado_q <= FIM;
                        end else begin
                            cnt_q <= nxt;
                        end
                    end
                end
                FIM: begin
                    ocupado_q <= 1'b0;
                    estado_q  <= IDLE;
                end
                default: estado_q <= RST_LOW;
            endcase
        end
    end

endmodule

// File: tb/tb_transmissor_oled_spi.sv
// Directed bench: power-up, frame content/latency, snapshot, pending
// merge, reset mid-frame, and CLK_DIV=1 timing on a second instance.
module tb_transmissor_oled_spi;

    localparam int TCK = 10;

    logic          clk;
    logic          rst_n;
    logic [8191:0] imagem;
    logic          atualizar;
    logic          ocupado0, pronto0;
    logic          ocupado1, pronto1;

    transmissor_oled_spi_if if0 ();
    transmissor_oled_spi_if if1 ();

    transmissor_oled_spi #(.CLK_DIV(2), .RST_CYCLES(8)) dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .imagem   (imagem),
        .atualizar(atualizar),
        .ocupado  (ocupado0),
        .pronto   (pronto0),
        .oled     (if0)
    );

    transmissor_oled_spi #(.CLK_DIV(1), .RST_CYCLES(8)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .imagem   (imagem),
        .atualizar(atualizar),
        .ocupado  (ocupado1),
        .pronto   (pronto1),
        .oled     (if1)
    );

    initial clk = 1'b0;
    always #(TCK / 2) clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // SPI monitors: decode bytes as {dc, byte}, check mosi/dc setup.
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [7:0] sh0, sh1;
    int         nb0, nb1, setup0, setup1, nr1;
    time        chg0, chg1;
    time        rt1[9];

    always @(if0.mosi or if0.dc) chg0 = $time;
    always @(if1.mosi or if1.dc) chg1 = $time;

    always @(posedge if0.sclk or posedge if0.cs_n) begin
        if (if0.cs_n) nb0 = 0;
        else begin
            if ($time - chg0 < 2 * TCK) setup0++;
            sh0 = {sh0[6:0], if0.mosi};
            nb0++;
            if (nb0 == 8) begin
                q0.push_back({if0.dc, sh0});
                nb0 = 0;
            end
        end
    end

    always @(posedge if1.sclk or posedge if1.cs_n) begin
        if (if1.cs_n) nb1 = 0;
        else begin
            if ($time - chg1 < TCK) setup1++;
            if (nr1 < 9) begin
                rt1[nr1] = $time;
                nr1++;
            end
            sh1 = {sh1[6:0], if1.mosi};
            nb1++;
            if (nb1 == 8) begin
                q1.push_back({if1.dc, sh1});
                nb1 = 0;
            end
        end
    end

    function automatic int erros_init(input logic [8:0] q[$],
                                      input int base);
        logic [7:0] ie [10];
        int e;
        ie = '{8'hAE, 8'h20, 8'h00, 8'h8D, 8'h14,
               8'hA1, 8'hC8, 8'h81, 8'h7F, 8'hAF};
        e = 0;
        for (int i = 0; i < 10; i++)
            if (base + i >= q.size()) e++;
            else if (q[base+i] !== {1'b0, ie[i]}) e++;
        return e;
    endfunction

    function automatic int erros_frame(input logic [8:0] q[$],
                                       input int base,
                                       input logic [7:0] b0,
                                       input logic [7:0] bl,
                                       input logic [7:0] resto);
        logic [7:0] ce [6];
        logic [8:0] x;
        int e;
        ce = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};
        e = 0;
        for (int i = 0; i < 1030; i++) begin
            if (i < 6) x = {1'b0, ce[i]};
            else if (i == 6) x = {1'b1, b0};
            else if (i == 1029) x = {1'b1, bl};
            else x = {1'b1, resto};
            if (base + i >= q.size()) e++;
            else if (q[base+i] !== x) e++;
        end
        return e;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dut0"},
            {if0.sclk, if0.mosi, if0.dc, if0.cs_n,
             if0.res_n, ocupado0, pronto0}, 7'b0001010);
        chk({tag, "_dut1"},
            {if1.sclk, if1.mosi, if1.dc, if1.cs_n,
             if1.res_n, ocupado1, pronto1}, 7'b0001010);
    endtask

    // Release reset and time the power-up sequence of dut0.
    task automatic sobe_reset(input string tag);
        int e_res, e_cs, e_idle, base;
        e_res = 0;
        e_cs = 0;
        e_idle = 0;
        base = q0.size();
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 2000 && e_idle == 0; e++) begin
            @(posedge clk);
            #1;
            if (e_res == 0 && if0.res_n) e_res = e;
            if (e_cs == 0 && !if0.cs_n) e_cs = e;
            if (e_idle == 0 && !ocupado0) e_idle = e;
        end
        chk({tag, "_res_n_rise"}, e_res, 8);
        chk({tag, "_cs_n_low"}, e_cs, 16);
        chk({tag, "_ocupado_fall"}, e_idle, 337);
        chk({tag, "_cs_n_idle"}, if0.cs_n, 1'b1);
        chk({tag, "_init_count"}, q0.size() - base, 10);
        chk({tag, "_init_bytes"}, erros_init(q0, base), 0);
    endtask

    initial begin
        int kp, base, n;
        rst_n     = 1'b0;
        atualizar = 1'b0;
        imagem    = '0;
        imagem[7:0]       = 8'hA5;
        imagem[8191:8184] = 8'h3C;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset_vals");

        sobe_reset("boot");
        chk("d1_idle", ocupado1, 1'b0);
        chk("d1_init_bytes", erros_init(q1, 0), 0);
        chk("d1_sclk_period", 32'(rt1[1] - rt1[0]), 2 * TCK);
        chk("d1_byte_len", 32'(rt1[8] - rt1[0]), 16 * TCK);

        // Frame 1: snapshot A5..3C; image changed and 3 requests mid-frame.
        @(negedge clk);
        atualizar = 1'b1;
        @(posedge clk);
        #1;
        atualizar = 1'b0;
        chk("f1_cs_n_start", if0.cs_n, 1'b0);
        chk("f1_ocupado_start", ocupado0, 1'b1);
        base = q0.size();
        kp = 0;
        for (int k = 1; k <= 40000 && kp == 0; k++) begin
            @(posedge clk);
            #1;
            atualizar = (k == 5000 || k == 10000 || k == 20000);
            if (k == 16000) imagem = '1;
            if (pronto0) kp = k;
        end
        chk("f1_latency", kp, 32961);
        chk("f1_count", q0.size() - base, 1030);
        chk("f1_bytes", erros_frame(q0, base, 8'hA5, 8'h3C, 8'h00), 0);
        @(posedge clk);
        #1;
        chk("f1_pronto_pulse", pronto0, 1'b0);
        chk("f1_ocupado_end", ocupado0, 1'b0);
        chk("f1_cs_n_end", if0.cs_n, 1'b1);
        @(posedge clk);
        #1;
        chk("f2_cs_n_start", if0.cs_n, 1'b0);
        chk("f2_ocupado_start", ocupado0, 1'b1);

        // Frame 2 comes from the merged pending request: all FF.
        base = q0.size();
        kp = 0;
        for (int k = 1; k <= 40000 && kp == 0; k++) begin
            @(posedge clk);
            #1;
            if (pronto0) kp = k;
        end
        chk("f2_latency", kp + 2, 32963);
        chk("f2_count", q0.size() - base, 1030);
        chk("f2_bytes", erros_frame(q0, base, 8'hFF, 8'hFF, 8'hFF), 0);

        base = q0.size();
        repeat (200) @(posedge clk);
        #1;
        chk("no_f3_bytes", q0.size() - base, 0);
        chk("no_f3_ocupado", ocupado0, 1'b0);
        chk("no_f3_cs_n", if0.cs_n, 1'b1);

        // Frame 3 aborted by reset at data byte 500.
        @(negedge clk);
        atualizar = 1'b1;
        @(posedge clk);
        #1;
        atualizar = 1'b0;
        base = q0.size();
        n = 0;
        for (int k = 1; k <= 20000 && n < 506; k++) begin
            @(posedge clk);
            #1;
            n = q0.size() - base;
        end
        chk("f3_bytes_before_reset", n, 506);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midframe_reset");
        repeat (3) @(negedge clk);
        sobe_reset("reboot");

        chk("setup_d2", setup0, 0);
        chk("setup_d1", setup1, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
